mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the LoongArch in-order core.
- Sits between the EX stage and the WB stage.
- Accepts the EX payload, waits for the data-SRAM response of any load/store issued in EX, and aligns and extends load data.
- Forwards the exception/CSR bundle and register-write bundle to WB. Provides the bypass, hazard and store-cancel signals upstream.
- Discards SRAM responses belonging to flushed instructions.

Parameters:
- CNT_W, 2, width of the outstanding-discard counter (max 3 responses).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- es2ms_valid  in  1  EX payload valid
- ms_allowin  out  1  MEM can accept this cycle
- es2ms_bus  in  163  {mem_req, ld_op[4:0]={w,hu,h,bu,b}, res_from_mem, csr_re, rf_we, rf_waddr[4:0], alu_result[31:0], pc[31:0], except_zip[84:0]}
- es_req_inflight  in  1  EX holds a request whose addr handshake completed but which has not yet moved to MEM
- data_sram_data_ok  in  1  response valid
- data_sram_rdata  in  32  response data
- ws_allowin  in  1  WB can accept
- ms2ws_valid  out  1  payload to WB valid
- ms2ws_bus  out  149  {vaddr=alu_result, pc, except_zip}
- ms_rf_zip  out  39  {csr_re, rf_we, rf_waddr, rf_wdata}; goes to WB and to ID bypass
- ms_ld_block  out  1  ID must stall: load or csr_re result not yet available
- ms_ex_to_es  out  1  valid MEM instruction carries an exception or ertn; EX suppresses its store
- wb_ex  in  1  exception flush from WB
- ertn_flush  in  1  ertn flush from WB

Behaviour:
- flush = wb_ex | ertn_flush.
- Reset values:
  - ms_valid=0, payload regs=0, data buffer=0, buf_valid=0, discard_cnt=0.
  - Hence ms2ws_valid=0, ms_ld_block=0, ms_ex_to_es=0, ms_rf_zip we-bit=0.
- Waiting rule:
  - need_data = ms_valid & mem_req.
  - ms_ready_go = ~need_data | buf_valid | (data_sram_data_ok & discard_cnt==0).
- Handshake:
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - ms2ws_valid = ms_valid & ms_ready_go & ~flush.
- ms_valid update:
  - flush -> 0 (priority over everything).
  - Else, if ms_allowin -> es2ms_valid.
  - Payload latches when es2ms_valid & ms_allowin & ~flush.
- Response buffer:
  - A data_ok accepted with discard_cnt==0 while ws_allowin=0 stores rdata and sets buf_valid.
  - buf_valid clears when the instruction leaves MEM or on flush.
  - At most one response per instruction; a second data_ok while buf_valid=1 is a protocol error and is ignored.
- Discard counter (reset mid-operation: resetn clears all):
  - On flush, increment by (ms_valid & mem_req & ~buf_valid & ~(data_sram_data_ok & discard_cnt==0)) + es_req_inflight.
  - On data_ok with discard_cnt>0, decrement. Simultaneous inc and dec net out.
  - A discarded response never reaches WB or the buffer.
  - Saturates at 2^CNT_W-1; overflow is a protocol error.
- Load data (rd = buf_valid ? buffer : rdata, off = alu_result[1:0]):
  - b/bu: byte rd[8*off+:8], sign/zero-extended to 32.
  - h/hu: half rd[16*off[1]+:16], sign/zero-extended to 32.
  - w: rd.
- Writeback data:
  - rf_wdata = res_from_mem ? load_data : alu_result.
  - csr_re passes through unchanged; WB substitutes the CSR value.
- ms_rf_zip:
  - we-bit = rf_we & ms_valid & ~(except_zip[6:0]!=0).
  - Address and data are unconditional.
- ms_ld_block = ms_valid & ((res_from_mem & ~ms_ready_go) | csr_re).
- ms_ex_to_es = ms_valid & (except_zip[6:0]!=0). Bit order is {int,brk,ine,adef,sys,ertn,ale}; ertn is bit 1.
- Exceptions:
  - EX never issues a request for an ale/adef instruction, so mem_req=0 and MEM passes through in 1 cycle.
- Latency:
  - Non-memory instruction: 1 cycle in MEM.
  - Load/store: until data_ok, minimum same cycle as entry.

Decomposition:
- Shared package:
  - bus widths: ES2MS 163, MS2WS 149, RF_ZIP 39, EXCEPT_ZIP 85.
  - except_zip bit indices and ld_op bit indices.
  - The same constants are used by the EX and WB stages.
- One sub-module, mem_load_align: purely combinational rd/off/ld_op to 32-bit result.

Test Plan:
- ALU op, pc=0x1c000010, alu_result=0x1234, rf_we=1, waddr=5 -> next cycle ms2ws_valid=1, ms_rf_zip={0,1,5,0x1234}, ms2ws_bus[148:117]=0x1234.
- ld.b at offset 3, rdata=0x80FF_0000, data_ok 2 cycles after entry -> ms_ld_block=1 for 2 cycles, then wdata=0xFFFFFF80; ld.bu same -> 0x00000080; ld.h off=2 -> 0xFFFF80FF.
- Load waiting, wb_ex pulsed with es_req_inflight=1 -> discard_cnt=2; next two data_ok dropped; third load's rdata=0xA5A5A5A5 delivered.
- data_ok arrives while ws_allowin=0 -> buffered, no second response needed; released when ws_allowin=1 with the correct data.
- Instruction with except_zip[0]=1 (ale), rf_we=1 -> ms_ex_to_es=1, rf_we-bit=0, passes in 1 cycle without waiting.
- resetn low while load waiting -> all outputs 0 next cycle, discard_cnt=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared bus layouts and field indices for the EX/MEM/WB stages.
// The EX and WB stages pack and unpack their buses with these constants.
package mem_stage_pkg;

  localparam int ES2MS_W      = 163;
  localparam int MS2WS_W      = 149;
  localparam int RF_ZIP_W     = 39;
  localparam int EXCEPT_ZIP_W = 85;

  localparam int EXC_ALE  = 0;
  localparam int EXC_ERTN = 1;
  localparam int EXC_SYS  = 2;
  localparam int EXC_ADEF = 3;
  localparam int EXC_INE  = 4;
  localparam int EXC_BRK  = 5;
  localparam int EXC_INT  = 6;
  localparam int EXC_CAUSE_W = 7;

  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  // Field order matches the es2ms_bus packing, MSB first.
  typedef struct packed {
    logic                    mem_req;
    logic [4:0]              ld_op;
    logic                    res_from_mem;
    logic                    csr_re;
    logic                    rf_we;
    logic [4:0]              rf_waddr;
    logic [31:0]             alu_result;
    logic [31:0]             pc;
    logic [EXCEPT_ZIP_W-1:0] except_zip;
  } es2ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the byte/half/word addressed by the
// low address bits and sign- or zero-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  off,
  input  logic [4:0]  ld_op,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = rd >> {off, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = off[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    result = rd;
    unique case (1'b1)
      ld_op[LD_B]:  result = {{24{byte_v[7]}}, byte_v};
      ld_op[LD_BU]: result = {24'h0, byte_v};
      ld_op[LD_H]:  result = {{16{half_v[15]}}, half_v};
      ld_op[LD_HU]: result = {16'h0, half_v};
      ld_op[LD_W]:  result = rd;
      default:      result = rd;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: waits for data-SRAM responses, aligns load data and
// drops responses that belong to instructions killed by a flush.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                es2ms_valid,
  output logic                ms_allowin,
  input  logic [ES2MS_W-1:0]  es2ms_bus,
  input  logic                es_req_inflight,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                ws_allowin,
  output logic                ms2ws_valid,
  output logic [MS2WS_W-1:0]  ms2ws_bus,
  output logic [RF_ZIP_W-1:0] ms_rf_zip,
  output logic                ms_ld_block,
  output logic                ms_ex_to_es,
  input  logic                wb_ex,
  input  logic                ertn_flush
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  es2ms_t           ms_r;
  logic             ms_valid;
  logic             buf_valid;
  logic [31:0]      buf_data;
  logic [CNT_W-1:0] discard_cnt;

  logic        flush;
  logic        cnt_zero;
  logic        data_live;
  logic        need_data;
  logic        ms_ready_go;
  logic        ms_leave;
  logic        has_ex;
  logic        buf_set;
  logic [31:0] rd;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  logic             inc_own;
  logic             dec;
  logic [CNT_W:0]   inc_cnt;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  assign flush     = wb_ex | ertn_flush;
  assign cnt_zero  = discard_cnt == '0;
  assign data_live = data_sram_data_ok & cnt_zero;
  assign need_data = ms_valid & ms_r.mem_req;

  assign ms_ready_go = ~need_data | buf_valid | data_live;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid & ms_ready_go & ~flush;
  assign ms_leave    = ms_valid & ms_ready_go & ws_allowin;

  assign has_ex = |ms_r.except_zip[EXC_CAUSE_W-1:0];

  assign rd = buf_valid ? buf_data : data_sram_rdata;

  mem_load_align u_align (
    .rd     (rd),
    .off    (ms_r.alu_result[1:0]),
    .ld_op  (ms_r.ld_op),
    .result (load_data)
  );

  assign rf_wdata = ms_r.res_from_mem ? load_data : ms_r.alu_result;

  assign ms2ws_bus = {ms_r.alu_result, ms_r.pc, ms_r.except_zip};
  assign ms_rf_zip = {ms_r.csr_re,
                      ms_r.rf_we & ms_valid & ~has_ex,
                      ms_r.rf_waddr,
                      rf_wdata};

  assign ms_ld_block = ms_valid &
                       ((ms_r.res_from_mem & ~ms_ready_go) | ms_r.csr_re);
  assign ms_ex_to_es = ms_valid & has_ex;

  // A killed request still owes a response: one from the waiting
  // instruction here, one from a request EX already handed to SRAM.
  assign inc_own = need_data & ~buf_valid & ~data_live;
  assign inc_cnt = flush ? ({{CNT_W{1'b0}}, inc_own}
                          + {{CNT_W{1'b0}}, es_req_inflight})
                         : '0;
  assign dec     = data_sram_data_ok & ~cnt_zero;
  assign cnt_sum = {1'b0, discard_cnt} + inc_cnt
                 - {{CNT_W{1'b0}}, dec};
  assign cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                        : cnt_sum[CNT_W-1:0];

  assign buf_set = need_data & ~buf_valid & data_live
                 & ~ws_allowin & ~flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      ms_r        <= '0;
      buf_valid   <= 1'b0;
      buf_data    <= 32'h0;
      discard_cnt <= '0;
    end else begin
      if (flush)
        ms_valid <= 1'b0;
      else if (ms_allowin)
        ms_valid <= es2ms_valid;

      if (es2ms_valid & ms_allowin & ~flush)
        ms_r <= es2ms_t'(es2ms_bus);

      if (flush | ms_leave)
        buf_valid <= 1'b0;
      else if (buf_set) begin
        buf_valid <= 1'b1;
        buf_data  <= data_sram_rdata;
      end

      discard_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized checks of the MEM stage against a
// behavioural model of load extraction and response ordering.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         es2ms_valid = 1'b0;
  logic         ms_allowin;
  logic [162:0] es2ms_bus = '0;
  logic         es_req_inflight = 1'b0;
  logic         data_sram_data_ok = 1'b0;
  logic [31:0]  data_sram_rdata = '0;
  logic         ws_allowin = 1'b1;
  logic         ms2ws_valid;
  logic [148:0] ms2ws_bus;
  logic [38:0]  ms_rf_zip;
  logic         ms_ld_block;
  logic         ms_ex_to_es;
  logic         wb_ex = 1'b0;
  logic         ertn_flush = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es2ms_valid       (es2ms_valid),
    .ms_allowin        (ms_allowin),
    .es2ms_bus         (es2ms_bus),
    .es_req_inflight   (es_req_inflight),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms2ws_valid       (ms2ws_valid),
    .ms2ws_bus         (ms2ws_bus),
    .ms_rf_zip         (ms_rf_zip),
    .ms_ld_block       (ms_ld_block),
    .ms_ex_to_es       (ms_ex_to_es),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [162:0] obs,
                     input logic [162:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [162:0] mk(
    input logic mem_req, input logic [4:0] ld_op,
    input logic res_mem, input logic csr_re, input logic we,
    input logic [4:0] waddr, input logic [31:0] alu,
    input logic [31:0] pc, input logic [84:0] exz);
    return {mem_req, ld_op, res_mem, csr_re, we, waddr, alu, pc, exz};
  endfunction

  // op: 0=b 1=bu 2=h 3=hu 4=w
  function automatic logic [31:0] ref_load(input int op,
    input logic [31:0] rd, input int off);
    longint v;
    longint u;
    u = longint'(rd);
    case (op)
      0: begin v = (u >> (8 * off)) % 256; if (v >= 128) v -= 256; end
      1: v = (u >> (8 * off)) % 256;
      2: begin v = (u >> (16 * (off / 2))) % 65536;
               if (v >= 32768) v -= 65536; end
      3: v = (u >> (16 * (off / 2))) % 65536;
      default: v = u;
    endcase
    return v[31:0];
  endfunction

  task automatic do_load(input int op, input int off,
    input logic [31:0] rdata, input int delay, input int stall);
    logic [31:0] exp;
    logic [31:0] alu;
    exp = ref_load(op, rdata, off);
    alu = 32'h1c00_2000 + 32'(off);
    @(negedge clk);
    es2ms_valid = 1'b1;
    ws_allowin  = 1'b1;
    es2ms_bus = mk(1'b1, 5'(1 << op), 1'b1, 1'b0, 1'b1, 5'd9, alu,
                   32'h1c00_0100, '0);
    @(negedge clk);
    es2ms_valid = 1'b0;
    for (int i = 0; i < delay; i++) begin
      #1;
      chk("ld_wait_block", 163'(ms_ld_block), 163'(1));
      chk("ld_wait_valid", 163'(ms2ws_valid), 163'(0));
      @(negedge clk);
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    ws_allowin        = (stall == 0);
    #1;
    chk("ld_ok_valid", 163'(ms2ws_valid), 163'(1));
    chk("ld_ok_block", 163'(ms_ld_block), 163'(0));
    chk("ld_ok_wdata", 163'(ms_rf_zip[31:0]), 163'(exp));
    for (int j = 0; j < stall; j++) begin
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = $urandom;
      ws_allowin        = (j == stall - 1);
      #1;
      chk("ld_buf_valid", 163'(ms2ws_valid), 163'(1));
      chk("ld_buf_wdata", 163'(ms_rf_zip[31:0]), 163'(exp));
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    ws_allowin = 1'b1;
    #1;
    chk("ld_gone", 163'(ms2ws_valid), 163'(0));
  endtask

  task automatic do_alu(input logic [31:0] alu, input logic [4:0] wa,
    input logic we, input logic [84:0] exz);
    logic ex;
    ex = exz[6:0] != 7'd0;
    @(negedge clk);
    es2ms_valid = 1'b1;
    ws_allowin  = 1'b1;
    es2ms_bus = mk(1'b0, 5'd0, 1'b0, 1'b0, we, wa, alu,
                   32'h1c00_0010, exz);
    @(negedge clk);
    es2ms_valid = 1'b0;
    #1;
    chk("alu_valid", 163'(ms2ws_valid), 163'(1));
    chk("alu_zip", 163'(ms_rf_zip),
        163'({1'b0, we & ~ex, wa, alu}));
    chk("alu_vaddr", 163'(ms2ws_bus[148:117]), 163'(alu));
    chk("alu_ex", 163'(ms_ex_to_es), 163'(ex));
  endtask

  initial begin
    // Reset
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 163'(ms2ws_valid), 163'(0));
    chk("rst_block", 163'(ms_ld_block), 163'(0));
    chk("rst_ex", 163'(ms_ex_to_es), 163'(0));
    chk("rst_zip", 163'(ms_rf_zip), 163'(0));
    chk("rst_allowin", 163'(ms_allowin), 163'(1));
    resetn = 1'b1;

    do_alu(32'h1234, 5'd5, 1'b1, '0);

    do_load(0, 3, 32'h80FF_0000, 2, 0);
    do_load(1, 3, 32'h80FF_0000, 2, 0);
    do_load(2, 2, 32'h80FF_0000, 0, 0);
    do_load(4, 0, 32'hDEAD_BEEF, 1, 2);

    do_alu(32'h55, 5'd7, 1'b1, 85'h1);
    do_alu(32'h66, 5'd8, 1'b1, 85'h2);

    // Flush kills waiting load; in-flight EX request also owed
    @(negedge clk);
    es2ms_valid = 1'b1;
    es2ms_bus = mk(1'b1, 5'b10000, 1'b1, 1'b0, 1'b1, 5'd3,
                   32'h100, 32'h1c00_0200, '0);
    @(negedge clk);
    es2ms_valid = 1'b0;
    #1;
    chk("dis_wait_block", 163'(ms_ld_block), 163'(1));
    @(negedge clk);
    wb_ex = 1'b1;
    es_req_inflight = 1'b1;
    #1;
    chk("dis_flush_valid", 163'(ms2ws_valid), 163'(0));
    @(negedge clk);
    wb_ex = 1'b0;
    es_req_inflight = 1'b0;
    es2ms_valid = 1'b1;
    es2ms_bus = mk(1'b1, 5'b10000, 1'b1, 1'b0, 1'b1, 5'd4,
                   32'h200, 32'h1c00_0204, '0);
    #1;
    chk("dis_allowin", 163'(ms_allowin), 163'(1));
    @(negedge clk);
    es2ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    #1;
    chk("dis_drop1", 163'(ms2ws_valid), 163'(0));
    @(negedge clk);
    data_sram_rdata = 32'h2222_2222;
    #1;
    chk("dis_drop2", 163'(ms2ws_valid), 163'(0));
    @(negedge clk);
    data_sram_rdata = 32'hA5A5_A5A5;
    #1;
    chk("dis_live_valid", 163'(ms2ws_valid), 163'(1));
    chk("dis_live_data", 163'(ms_rf_zip[31:0]), 163'(32'hA5A5_A5A5));
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    chk("dis_gone", 163'(ms2ws_valid), 163'(0));

    // ertn flush of an ALU op in MEM
    @(negedge clk);
    es2ms_valid = 1'b1;
    es2ms_bus = mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2,
                   32'h77, 32'h1c00_0300, '0);
    @(negedge clk);
    es2ms_valid = 1'b0;
    ertn_flush = 1'b1;
    #1;
    chk("ertn_valid", 163'(ms2ws_valid), 163'(0));
    @(negedge clk);
    ertn_flush = 1'b0;
    #1;
    chk("ertn_cleared", 163'(ms_rf_zip[37]), 163'(0));

    // Reset while a load waits with responses owed
    @(negedge clk);
    es2ms_valid = 1'b1;
    es2ms_bus = mk(1'b1, 5'b10000, 1'b1, 1'b0, 1'b1, 5'd6,
                   32'h300, 32'h1c00_0400, 85'h0);
    @(negedge clk);
    es2ms_valid = 1'b0;
    wb_ex = 1'b1;
    es_req_inflight = 1'b1;
    @(negedge clk);
    wb_ex = 1'b0;
    es_req_inflight = 1'b0;
    es2ms_valid = 1'b1;
    @(negedge clk);
    es2ms_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_valid", 163'(ms2ws_valid), 163'(0));
    chk("mrst_block", 163'(ms_ld_block), 163'(0));
    chk("mrst_zip", 163'(ms_rf_zip), 163'(0));
    chk("mrst_bus", 163'(ms2ws_bus), 163'(0));
    resetn = 1'b1;
    do_load(4, 0, 32'hCAFE_F00D, 0, 0);

    // Randomized mix against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_alu($urandom, 5'($urandom_range(1, 31)), 1'($urandom), '0);
      else
        do_load($urandom_range(0, 4), $urandom_range(0, 3), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
